led_sprite_reader: RTL and testbench
====================================

# led_sprite_reader

Reads a 32×32 RGB565 LED sprite from the two Gowin pROM image blocks (LED-on and LED-off, shared address bus, READ_MODE bypass) and overlays it on the VGA pixel stream. It sits between the VGA timing generator and the video output. Each cycle it turns the current beam coordinate into a ROM address, absorbs the ROM read latency, and emits a pixel-aligned RGB565 value with sync signals delayed to match. Position, scale and LED state are latched once per frame so the sprite never tears.

## Interface
Parameters:
- VS_ACTIVE, 1'b0, active level of `vs_in`.
- H_BITS, 10, width of the beam coordinate buses.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- x_in  in  H_BITS  current beam column.
- y_in  in  H_BITS  current beam row.
- de_in  in  1  display enable.
- hs_in  in  1  horizontal sync.
- vs_in  in  1  vertical sync.
- pos_x  in  H_BITS  sprite left column, sampled at frame start.
- pos_y  in  H_BITS  sprite top row, sampled at frame start.
- scale  in  2  0 = 1×, 1 = 2×, 2 = 4×, 3 = 4×; sampled at frame start.
- led_on  in  1  selects the on-image or off-image; sampled at frame start.
- bg_rgb  in  16  colour shown outside the sprite or on transparent pixels.
- rom_ad  out  10  shared ROM address, {row[4:0], col[4:0]}.
- rom_ce  out  1  ROM clock enable.
- rom_oce  out  1  ROM output clock enable; constant 1.
- rom_reset  out  1  ROM reset; constant 0.
- rom_on_dout  in  16  LED-on ROM data.
- rom_off_dout  in  16  LED-off ROM data.
- rgb_out  out  16  output pixel, RGB565.
- de_out, hs_out, vs_out  out  1 each  syncs aligned with `rgb_out`.

## Operation
- **Frame latch.** The cycle after `vs_in` changes to VS_ACTIVE, register pos_x, pos_y, scale and led_on into their shadow copies. All hit tests and image selection use only the shadows.
- **Size.** `size = 32 << scale_eff`, where scale_eff = min(scale, 2).
- **Hit test.** Done in H_BITS+1 unsigned arithmetic:
  - dx = x_in − pos_x_s and dy = y_in − pos_y_s.
  - hit = de_in ∧ x_in ≥ pos_x_s ∧ y_in ≥ pos_y_s ∧ dx < size ∧ dy < size.
  - Wrap is never a hit. A sprite placed partly past the screen edge is clipped, with no aliasing.
- **Address.** rom_ad = {(dy >> scale_eff)[4:0], (dx >> scale_eff)[4:0]}. When hit = 0, rom_ad holds its last value.
- **ROM enable.** rom_ce is a register: reset 0, then 1 from the first cycle after reset is released.
- **Pixel select.**
  - Choose the image with led_on_s delayed to the data stage. The shadow cannot change mid-frame, so the delay is only for pipeline consistency.
  - pix = chosen dout.
  - If not de: rgb_out = 0.
  - Else if hit_d and pix ≠ 16'h0000: rgb_out = pix.
  - Else: rgb_out = bg_rgb, delayed to align with the pixel.
  - 16'h0000 is the transparency key.

## Timing
- **Pipeline** (beam sample at edge N):
  - S1 at edge N+1: rom_ad and hit registered; syncs and bg_rgb enter the delay.
  - ROM samples rom_ad at edge N+2; dout is valid in cycle N+2.
  - S3 at edge N+3: rgb_out, de_out, hs_out and vs_out registered.
- **Latency.** Fixed at 3 clocks from x_in/y_in/de_in/hs_in/vs_in to the outputs. All four outputs share this latency, with no bubbles and no stalls.
- **Reset values.** rgb_out = 0, de_out = 0, hs_out = 1, vs_out = ¬VS_ACTIVE, rom_ad = 0, rom_ce = 0. Shadows are pos 0, scale 0, led_on 0. The delay stages are flushed to the same idle values.
- **Reset mid-frame.** Outputs go to reset values immediately (asynchronous). After release, the first 3 output cycles carry idle values. Shadows stay at 0 until the next frame latch.
- **Simultaneous events.** When the vs transition and a hit occur in the same cycle, the hit uses the old shadows and the latch takes effect on the next cycle. This is harmless because de_in is low during vsync.
- **Sync delays.** hs and vs delays are pure shift registers: no glitches, edges preserved exactly.

## Structure
- Package `led_sprite_pkg` holds:
  - SPRITE_DIM = 32, ROM_AW = 10, PIX_W = 16, TRANSPARENT = 16'h0000.
  - Scale encoding constants and a `scale_eff` function.
- Sub-module `pipe_delay`, parameters WIDTH, DEPTH and RESET_VAL. It is instantiated for the {de, hs, vs, bg_rgb} bundle (DEPTH 3) and for hit/led_on (DEPTH 2).

## Test plan
- **Reset, then steady stream.** Hold rst_n low with de_in = 1 → rgb_out = 0 and rom_ce = 0. After release, rom_ce = 1 one cycle later, and outputs follow inputs with exactly 3 cycles of latency.
- **1× placement.** pos = (100, 50), led_on = 1, ROM model = on-image. At beam (100, 50), rom_ad = 0. At (131, 81), rom_ad = 1023. rgb_out equals the ROM word, or bg_rgb where the word is 0x0000. Beam (132, 50) → bg_rgb.
- **2× scale.** scale = 1, pos = (0, 0). Beam (63, 63) → rom_ad = 1023. Beam (64, 0) → no hit. Each ROM pixel repeats on 2 columns and 2 rows.
- **Clipping.** pos_x = 630 on a 640-wide frame → only columns 630–639 hit, using ROM cols 0–9. pos_x = 1020 with x_in = 2 → no hit (no wrap).
- **Frame latch.** Change pos_x and led_on mid-frame → no change until after the next vs_in active edge. The following frame uses the off-image and the new position.
- **Async reset mid-line.** Pull rst_n low asynchronously while a hit is in flight → outputs go to idle immediately, with no stale sprite pixel after release.

Source files
------------

// File: rtl/led_sprite_pkg.sv
// rtl/led_sprite_pkg.sv - shared constants and scale helper for the LED sprite reader
//
// Holds the sprite geometry, ROM address width, pixel width, the
// transparency key and the scale encoding used by led_sprite_reader.
package led_sprite_pkg;

  localparam int SPRITE_DIM = 32;
  localparam int ROM_AW     = 10;
  localparam int PIX_W      = 16;
  localparam int COORD_W    = ROM_AW / 2;

  localparam logic [PIX_W-1:0] TRANSPARENT = 16'h0000;

  typedef enum logic [1:0] {
    SCALE_1X     = 2'd0,
    SCALE_2X     = 2'd1,
    SCALE_4X     = 2'd2,
    SCALE_4X_ALT = 2'd3
  } scale_e;

  // Encoding 3 is an alias for 4x, so the shift amount saturates at 2.
  function automatic logic [1:0] scale_eff(input logic [1:0] scale);
    return (scale > SCALE_4X) ? SCALE_4X : scale;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - fixed-depth register delay line with reset value
//
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset, loads RESET_VAL in every stage
//   data    - value entering the delay line
//   delayed - value that entered DEPTH clocks earlier
module pipe_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign delayed = stage_q[DEPTH-1];

endmodule

// File: rtl/led_sprite_reader.sv
// rtl/led_sprite_reader.sv - overlays a 32x32 RGB565 ROM sprite on a VGA pixel stream
//
// Ports:
//   clk, rst_n                 - pixel clock, asynchronous active-low reset
//   x_in, y_in, de_in          - beam position and display enable
//   hs_in, vs_in               - syncs from the timing generator
//   pos_x, pos_y, scale,led_on - sprite placement, latched at frame start
//   bg_rgb                     - colour outside the sprite / on transparent pixels
//   rom_ad, rom_ce, rom_oce,
//   rom_reset                  - shared control of the on/off image ROMs
//   rom_on_dout, rom_off_dout  - ROM read data (one clock after address)
//   rgb_out, de_out, hs_out,
//   vs_out                     - output pixel and syncs, 3 clocks after input
module led_sprite_reader
  import led_sprite_pkg::*;
#(
  parameter logic VS_ACTIVE = 1'b0,
  parameter int   H_BITS    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [H_BITS-1:0] x_in,
  input  logic [H_BITS-1:0] y_in,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [H_BITS-1:0] pos_x,
  input  logic [H_BITS-1:0] pos_y,
  input  logic [1:0]        scale,
  input  logic              led_on,
  input  logic [PIX_W-1:0]  bg_rgb,
  output logic [ROM_AW-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [PIX_W-1:0]  rom_on_dout,
  input  logic [PIX_W-1:0]  rom_off_dout,
  output logic [PIX_W-1:0]  rgb_out,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out
);

  // One extra bit so a beam left of / above the sprite cannot wrap into a hit.
  localparam int CW = H_BITS + 1;

  logic              vs_prev;
  logic              frame_start;
  logic [H_BITS-1:0] pos_x_s;
  logic [H_BITS-1:0] pos_y_s;
  logic [1:0]        scale_s;
  logic              led_on_s;

  logic [1:0]         shift;
  logic [CW-1:0]      size;
  logic [CW-1:0]      dx;
  logic [CW-1:0]      dy;
  logic               hit;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;

  logic              hit_d;
  logic              led_d;
  logic [PIX_W-1:0]  pix;
  logic [PIX_W-1:0]  sprite_q;
  logic [PIX_W-1:0]  bg_d;

  assign rom_oce   = 1'b1;
  assign rom_reset = 1'b0;

  // Shadows load on the clock after vs_in enters its active level, so a
  // hit in that same cycle still sees the previous frame's placement.
  assign frame_start = (vs_in == VS_ACTIVE) && (vs_prev != VS_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev  <= ~VS_ACTIVE;
      pos_x_s  <= '0;
      pos_y_s  <= '0;
      scale_s  <= SCALE_1X;
      led_on_s <= 1'b0;
    end else begin
      vs_prev <= vs_in;
      if (frame_start) begin
        pos_x_s  <= pos_x;
        pos_y_s  <= pos_y;
        scale_s  <= scale;
        led_on_s <= led_on;
      end
    end
  end

  assign shift = scale_eff(scale_s);
  assign size  = CW'(SPRITE_DIM) << shift;
  assign dx    = {1'b0, x_in} - {1'b0, pos_x_s};
  assign dy    = {1'b0, y_in} - {1'b0, pos_y_s};
  assign hit   = de_in && (x_in >= pos_x_s) && (y_in >= pos_y_s) &&
                 (dx < size) && (dy < size);
  assign col   = COORD_W'(dx >> shift);
  assign row   = COORD_W'(dy >> shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_ad <= '0;
      rom_ce <= 1'b0;
    end else begin
      rom_ce <= 1'b1;
      if (hit) rom_ad <= {row, col};
    end
  end

  // hit and image select travel alongside the ROM read so they line up
  // with dout in the data stage.
  pipe_delay #(
    .WIDTH     (2),
    .DEPTH     (2),
    .RESET_VAL (2'b00)
  ) u_hit_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    ({hit, led_on_s}),
    .delayed ({hit_d, led_d})
  );

  pipe_delay #(
    .WIDTH     (3 + PIX_W),
    .DEPTH     (3),
    .RESET_VAL ({1'b0, 1'b1, ~VS_ACTIVE, {PIX_W{1'b0}}})
  ) u_sync_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    ({de_in, hs_in, vs_in, bg_rgb}),
    .delayed ({de_out, hs_out, vs_out, bg_d})
  );

  assign pix = led_d ? rom_on_dout : rom_off_dout;

  // The final stage keeps only the sprite colour; a stored TRANSPARENT
  // value means "show background", which is why the key doubles as the
  // miss marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_q <= TRANSPARENT;
    end else begin
      sprite_q <= (hit_d && (pix != TRANSPARENT)) ? pix : TRANSPARENT;
    end
  end

  assign rgb_out = !de_out                    ? '0       :
                   (sprite_q != TRANSPARENT)  ? sprite_q :
                                                bg_d;

endmodule

// File: tb/tb_led_sprite_reader.sv
// tb/tb_led_sprite_reader.sv - self-checking bench for led_sprite_reader
module tb_led_sprite_reader;

  localparam bit VS_ACT = 1'b0;
  localparam int HB     = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HB-1:0] x_in, y_in, pos_x, pos_y;
  logic          de_in, hs_in, vs_in, led_on;
  logic [1:0]    scale;
  logic [15:0]   bg_rgb;
  logic [9:0]    rom_ad;
  logic          rom_ce, rom_oce, rom_reset;
  logic [15:0]   rom_on_dout, rom_off_dout;
  logic [15:0]   rgb_out;
  logic          de_out, hs_out, vs_out;

  led_sprite_reader #(.VS_ACTIVE(VS_ACT), .H_BITS(HB)) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .de_in(de_in),
    .hs_in(hs_in), .vs_in(vs_in), .pos_x(pos_x), .pos_y(pos_y),
    .scale(scale), .led_on(led_on), .bg_rgb(bg_rgb), .rom_ad(rom_ad),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
    .rom_on_dout(rom_on_dout), .rom_off_dout(rom_off_dout),
    .rgb_out(rgb_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  logic [15:0] on_mem  [1024];
  logic [15:0] off_mem [1024];

  // ROM model: registered read, address sampled when rom_ce is high.
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_on_dout  <= on_mem[rom_ad];
      rom_off_dout <= off_mem[rom_ad];
    end
  end

  typedef struct packed {
    logic [15:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } out_t;

  out_t       exp_q[$];
  logic [9:0] exp_ad;
  int         sh_px, sh_py, sh_sc;
  bit         sh_led;
  bit         vs_prev_m;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic reset_model();
    out_t idle;
    idle = '{rgb: 16'h0, de: 1'b0, hs: 1'b1, vs: !VS_ACT};
    exp_q.delete();
    exp_q.push_back(idle);
    exp_q.push_back(idle);
    exp_ad    = '0;
    sh_px     = 0;
    sh_py     = 0;
    sh_sc     = 0;
    sh_led    = 0;
    vs_prev_m = !VS_ACT;
  endtask

  // One beam cycle: apply inputs, predict, clock, compare.
  task automatic step(input int x, input int y, input bit de, input bit hs,
                      input bit vs, input logic [15:0] bg);
    int   s, size, col, row, addr;
    bit   hit;
    out_t e, got;
    logic [15:0] word;
    x_in = 10'(x); y_in = 10'(y); de_in = de; hs_in = hs; vs_in = vs; bg_rgb = bg;
    s    = (sh_sc > 2) ? 2 : sh_sc;
    size = 32 << s;
    hit  = de && (x >= sh_px) && (y >= sh_py) && (x - sh_px < size) && (y - sh_py < size);
    e.rgb = de ? bg : 16'h0;
    if (hit) begin
      col  = (x - sh_px) / (1 << s);
      row  = (y - sh_py) / (1 << s);
      addr = row * 32 + col;
      word = sh_led ? on_mem[addr] : off_mem[addr];
      if (word != 16'h0) e.rgb = word;
      exp_ad = 10'(addr);
    end
    e.de = de; e.hs = hs; e.vs = vs;
    exp_q.push_back(e);
    if (vs == VS_ACT && vs_prev_m != VS_ACT) begin
      sh_px = int'(pos_x); sh_py = int'(pos_y); sh_sc = int'(scale); sh_led = led_on;
    end
    vs_prev_m = vs;
    @(posedge clk); #1;
    got = {rgb_out, de_out, hs_out, vs_out};
    e   = exp_q.pop_front();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL pixel beam=(%0d,%0d): observed rgb=%h de=%b hs=%b vs=%b expected rgb=%h de=%b hs=%b vs=%b",
             x, y, got.rgb, got.de, got.hs, got.vs, e.rgb, e.de, e.hs, e.vs);
    end
    vectors++;
    assert (rom_ad === exp_ad) else begin
      miscompares++;
      $error("FAIL rom_ad beam=(%0d,%0d): observed %0d expected %0d", x, y, rom_ad, exp_ad);
    end
  endtask

  task automatic new_frame();
    step(0, 0, 0, 1, !VS_ACT, 16'h0);
    step(0, 0, 0, 1, VS_ACT, 16'h0);
    step(0, 0, 0, 0, VS_ACT, 16'h0);
    step(0, 0, 0, 1, !VS_ACT, 16'h0);
  endtask

  task automatic rand_steps(input int n, input int xlo, input int xhi,
                            input int ylo, input int yhi);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(xhi, xlo), $urandom_range(yhi, ylo),
           ($urandom % 5) != 0, 1'($urandom), !VS_ACT, 16'($urandom));
    end
  endtask

  task automatic place(input int px, input int py, input int sc, input bit led);
    pos_x = 10'(px); pos_y = 10'(py); scale = 2'(sc); led_on = led;
  endtask

  initial begin
    int unsigned r;
    for (int i = 0; i < 1024; i++) begin
      r = $urandom;
      on_mem[i]  = (r % 8 == 0) ? 16'h0 : r[15:0];
      r = $urandom;
      off_mem[i] = (r % 8 == 0) ? 16'h0 : r[15:0];
    end

    // Reset held with an active stream.
    rst_n = 1'b0;
    x_in = 10'd100; y_in = 10'd50; de_in = 1'b1; hs_in = 1'b1; vs_in = !VS_ACT;
    bg_rgb = 16'h1234;
    place(100, 50, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 32'(rgb_out), 32'h0);
    check("reset_de", 32'(de_out), 32'h0);
    check("reset_hs", 32'(hs_out), 32'h1);
    check("reset_vs", 32'(vs_out), 32'(!VS_ACT));
    check("reset_rom_ce", 32'(rom_ce), 32'h0);
    check("reset_rom_ad", 32'(rom_ad), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rom_ce_before_edge", 32'(rom_ce), 32'h0);
    reset_model();
    step(5, 5, 1, 1, !VS_ACT, 16'hbeef);
    check("rom_ce_after_edge", 32'(rom_ce), 32'h1);
    check("rom_oce", 32'(rom_oce), 32'h1);
    check("rom_reset", 32'(rom_reset), 32'h0);
    rand_steps(10, 0, 40, 0, 40);

    // 1x placement, on-image.
    new_frame();
    step(100, 50, 1, 1, !VS_ACT, 16'h0f0f);
    check("1x_origin_ad", 32'(rom_ad), 32'd0);
    step(131, 81, 1, 1, !VS_ACT, 16'h0f0f);
    check("1x_corner_ad", 32'(rom_ad), 32'd1023);
    step(132, 50, 1, 1, !VS_ACT, 16'h0f0f);
    rand_steps(200, 90, 140, 40, 90);

    // Mid-frame change is ignored until the next frame start.
    place(300, 50, 0, 1'b0);
    rand_steps(100, 90, 140, 40, 90);
    new_frame();
    rand_steps(150, 290, 340, 40, 90);
    rand_steps(30, 90, 140, 40, 90);

    // 2x and 4x scale.
    place(0, 0, 1, 1'b1);
    new_frame();
    step(63, 63, 1, 1, !VS_ACT, 16'h00aa);
    check("2x_corner_ad", 32'(rom_ad), 32'd1023);
    step(64, 0, 1, 1, !VS_ACT, 16'h00aa);
    check("2x_miss_holds_ad", 32'(rom_ad), 32'd1023);
    rand_steps(200, 0, 70, 0, 70);
    place(8, 8, 2, 1'b0);
    new_frame();
    rand_steps(100, 0, 140, 0, 140);
    place(8, 8, 3, 1'b1);
    new_frame();
    rand_steps(100, 0, 140, 0, 140);

    // Right-edge clipping and no wraparound.
    place(630, 10, 0, 1'b1);
    new_frame();
    for (int x = 620; x < 640; x++) step(x, 20, 1, 1, !VS_ACT, 16'h5555);
    step(630, 20, 1, 1, !VS_ACT, 16'h5555);
    check("clip_col0_ad", 32'(rom_ad), 32'd320);
    place(1020, 10, 0, 1'b0);
    new_frame();
    step(2, 20, 1, 1, !VS_ACT, 16'h7777);
    check("no_wrap_ad_holds", 32'(rom_ad), 32'd320);
    rand_steps(60, 0, 40, 10, 41);
    rand_steps(30, 1015, 1023, 10, 41);

    // Asynchronous reset with sprite pixels in flight.
    place(100, 50, 0, 1'b1);
    new_frame();
    step(110, 60, 1, 1, !VS_ACT, 16'h2222);
    step(111, 60, 1, 1, !VS_ACT, 16'h2222);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rgb", 32'(rgb_out), 32'h0);
    check("async_de", 32'(de_out), 32'h0);
    check("async_hs", 32'(hs_out), 32'h1);
    check("async_vs", 32'(vs_out), 32'(!VS_ACT));
    check("async_rom_ce", 32'(rom_ce), 32'h0);
    check("async_rom_ad", 32'(rom_ad), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
    step(110, 60, 1, 1, !VS_ACT, 16'h3333);
    step(111, 60, 1, 1, !VS_ACT, 16'h3333);
    rand_steps(60, 0, 40, 0, 40);
    new_frame();
    rand_steps(60, 90, 140, 40, 90);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
